ddr_init_sequencer: RTL and testbench
=====================================

// Module: ddr_init_sequencer
// PURPOSE
//  Parametrised successor of the DDR setup block. After DDR calibration, fills a configurable
//  address window over Avalon-MM with a selectable pattern using bursts, then flags done/fail.
//  Sits between the DDR controller's Avalon slave and system reset/status logic.
//  Adds: calibration timeout, restart command, progress count, optional readback verify.
// PARAMETERS
//  ADDR_W       25     Avalon word-address width
//  DATA_W       256    Avalon data width; byteenable width = DATA_W/8
//  BURST_LEN    64     beats per burst, 1..2**(BCNT_W-1)
//  BCNT_W       7      burstcount width
//  BASE_ADDR    0      first word address of fill window
//  NUM_BURSTS   1024   bursts in window; window = NUM_BURSTS*BURST_LEN words, must fit ADDR_W
//  CAL_TIMEOUT  2**24  clk cycles to wait for cal_success before failing
//  PATTERN      1      0: all-zero; 1: each 32-bit lane = word address
//  AUTO_START   1      1: start automatically after reset; 0: wait for start_cmd
// PORTS
//  clk               in   1          single clock; all inputs synchronous to it
//  rst_n             in   1          asynchronous active-low reset
//  cal_success       in   1          DDR calibration passed (level)
//  cal_fail          in   1          DDR calibration failed (level)
//  start_cmd         in   1          1-cycle pulse: (re)start fill
//  amm_addr          out  ADDR_W     burst start address
//  amm_burstcount    out  BCNT_W     = BURST_LEN
//  amm_byteenable    out  DATA_W/8   all ones
//  amm_write         out  1          write beat valid
//  amm_writedata     out  DATA_W     pattern data
//  amm_read          out  1          read burst request (verify only)
//  amm_readdata      in   DATA_W     read data
//  amm_readdatavalid in   1          read beat valid
//  amm_ready         in   1          slave accepts command/beat (active high)
//  busy              out  1          sequence in progress
//  setup_done        out  1          fill (and verify) completed OK; sticky
//  setup_fail        out  1          timeout / cal_fail / verify mismatch; sticky
//  progress          out  32         bursts completed in current phase
// BEHAVIOUR
//  Reset: all outputs 0; FSM to IDLE; counters 0. Reset mid-sequence aborts instantly.
//  FSM: IDLE -> WAIT_CAL on AUTO_START after reset or start_cmd; clears done/fail/progress.
//   WAIT_CAL: cal_success -> WRITE; cal_fail or timer==CAL_TIMEOUT-1 -> FAIL.
//   WRITE: amm_write=1, amm_addr=BASE_ADDR+burst*BURST_LEN held for whole burst.
//     Beat advances only when amm_write&&amm_ready; hold all outputs while !amm_ready.
//     Word addr for data = amm_addr+beat. Last beat of last burst accepted -> VERIFY or DONE.
//   DONE: setup_done=1 next cycle; busy=0. FAIL: setup_fail=1; busy=0.
//  progress increments on each burst's final accepted beat; 32-bit, no wrap in range.
//  start_cmd while busy: ignored. start_cmd in DONE/FAIL: restart, flags cleared same edge.
//  cal_fail during WRITE/VERIFY ignored (controller already calibrated).
//  amm_write and amm_read never asserted together.
// CONFIGURATION
//  DDR_INIT_VERIFY_EN defined: after WRITE, VERIFY state issues NUM_BURSTS read bursts
//   (amm_read one cycle per accepted command, next command only after all BURST_LEN beats
//   of previous returned), compares each readdatavalid beat to expected pattern;
//   first mismatch -> FAIL, remaining beats drained before FAIL asserted. progress restarts at 0.
//  Not defined: VERIFY state, compare logic absent; amm_read tied 0; WRITE -> DONE.
// STRUCTURE
//  Package ddr_init_pkg: FSM state enum, PATTERN_ZERO/PATTERN_ADDR constants,
//   function gen_pattern(addr) -> DATA_W word.
//  Sub-module ddr_init_pattern_gen: combinational pattern from word address (shared by
//   write and verify paths). Top holds FSM, burst/beat/timeout counters, Avalon regs.
// TESTING
//  1 BURST_LEN=4,NUM_BURSTS=3,PATTERN=1, cal_success at cycle 10, amm_ready=1 ->
//    12 beats, addrs 0,4,8, data lanes = 0..11, setup_done 1 cycle after last beat, progress=3.
//  2 Random amm_ready low 50% -> addr/data/burstcount stable while stalled; same final data.
//  3 CAL_TIMEOUT=100, cal_success never -> setup_fail at cycle 100 after WAIT_CAL entry, no write.
//  4 cal_fail=1 in WAIT_CAL -> setup_fail next cycle; start_cmd then cal_success -> setup_done.
//  5 rst_n low mid-burst 2 -> outputs 0 immediately; after release AUTO_START refills from BASE.
//  6 VERIFY_EN, slave corrupts beat 5 -> setup_fail after drain; clean memory -> setup_done.

Source files
------------

// File: rtl/ddr_init_pkg.sv
// Shared FSM state type, pattern selectors and the per-lane pattern function
// for the DDR init sequencer.
package ddr_init_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_WAIT_CAL = 3'd1,
      ST_WRITE    = 3'd2,
      ST_VERIFY   = 3'd3,
      ST_DONE     = 3'd4,
      ST_FAIL     = 3'd5
   } seq_state_e;

   localparam int PATTERN_ZERO = 0;
   localparam int PATTERN_ADDR = 1;

   // Value of one 32-bit lane for a given word address; replicated across the bus.
   function automatic logic [31:0] gen_pattern(input logic [31:0] word_addr, input int pattern);
      return (pattern == PATTERN_ADDR) ? word_addr : 32'd0;
   endfunction

endpackage

// File: rtl/ddr_init_pattern_gen.sv
// Combinational fill pattern for one Avalon word; shared by the write and
// readback-verify datapaths so both always agree on the expected data.
module ddr_init_pattern_gen
   import ddr_init_pkg::*;
#(
   parameter int ADDR_W  = 25,
   parameter int DATA_W  = 256,
   parameter int PATTERN = 1
) (
   input  logic [ADDR_W-1:0] word_addr,
   output logic [DATA_W-1:0] data
);

   logic [31:0] lane;

   always_comb begin
      lane = gen_pattern(32'(word_addr), PATTERN);
      data = '0;
      for (int i = 0; i < DATA_W; i++) begin
         data[i] = lane[i % 32];
      end
   end

endmodule

// File: rtl/ddr_init_sequencer.sv
// DDR init sequencer: waits for calibration, then fills an address window with a
// pattern using Avalon-MM write bursts. Define DDR_INIT_VERIFY_EN for a readback-verify pass.
module ddr_init_sequencer
   import ddr_init_pkg::*;
#(
   parameter int ADDR_W      = 25,
   parameter int DATA_W      = 256,
   parameter int BURST_LEN   = 64,
   parameter int BCNT_W      = 7,
   parameter int BASE_ADDR   = 0,
   parameter int NUM_BURSTS  = 1024,
   parameter int CAL_TIMEOUT = 2**24,
   parameter int PATTERN     = 1,
   parameter int AUTO_START  = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  cal_success,
   input  logic                  cal_fail,
   input  logic                  start_cmd,
   output logic [ADDR_W-1:0]     amm_addr,
   output logic [BCNT_W-1:0]     amm_burstcount,
   output logic [DATA_W/8-1:0]   amm_byteenable,
   output logic                  amm_write,
   output logic [DATA_W-1:0]     amm_writedata,
   output logic                  amm_read,
   input  logic [DATA_W-1:0]     amm_readdata,
   input  logic                  amm_readdatavalid,
   input  logic                  amm_ready,
   output logic                  busy,
   output logic                  setup_done,
   output logic                  setup_fail,
   output logic [31:0]           progress,
   output logic [2:0]            dbg_state
);

   localparam logic [31:0] BEAT_LAST  = 32'(BURST_LEN - 1);
   localparam logic [31:0] BURST_LAST = 32'(NUM_BURSTS - 1);
   localparam logic [31:0] TIMER_LAST = 32'(CAL_TIMEOUT - 1);

   seq_state_e        state_q, state_d;
   logic [31:0]       timer_q, timer_d;
   logic [31:0]       burst_q, burst_d;
   logic [31:0]       beat_q, beat_d;
   logic [31:0]       progress_q, progress_d;
   logic              done_q, done_d;
   logic              fail_q, fail_d;
   logic              start_go;
   logic              cmd_active;
   logic [ADDR_W-1:0] burst_addr;
   logic [ADDR_W-1:0] word_addr;
   logic [DATA_W-1:0] pat_data;

`ifdef DDR_INIT_VERIFY_EN
   logic rd_wait_q, rd_wait_d;
   logic mismatch_q, mismatch_d;
   logic beat_bad;
`else
   logic unused_rd;
   assign unused_rd = ^{amm_readdata, amm_readdatavalid};
`endif

   assign burst_addr = ADDR_W'(BASE_ADDR) + ADDR_W'(burst_q * BURST_LEN);
   assign word_addr  = burst_addr + ADDR_W'(beat_q);

   ddr_init_pattern_gen #(
      .ADDR_W  (ADDR_W),
      .DATA_W  (DATA_W),
      .PATTERN (PATTERN)
   ) u_pattern (
      .word_addr (word_addr),
      .data      (pat_data)
   );

   // Handshake: a command or write beat transfers on a cycle where amm_write or
   // amm_read is high together with amm_ready; while amm_ready is low every command
   // field is held unchanged. Read beats transfer on amm_readdatavalid with no backpressure.
   always_comb begin
      state_d    = state_q;
      timer_d    = timer_q;
      burst_d    = burst_q;
      beat_d     = beat_q;
      progress_d = progress_q;
      done_d     = done_q;
      fail_d     = fail_q;
      start_go   = 1'b0;
`ifdef DDR_INIT_VERIFY_EN
      rd_wait_d  = rd_wait_q;
      mismatch_d = mismatch_q;
      beat_bad   = 1'b0;
`endif
      case (state_q)
         ST_IDLE: start_go = start_cmd || (AUTO_START != 0);
         ST_WAIT_CAL: begin
            if (cal_success) begin
               state_d = ST_WRITE;
            end else if (cal_fail || timer_q == TIMER_LAST) begin
               state_d = ST_FAIL;
               fail_d  = 1'b1;
            end else begin
               timer_d = timer_q + 32'd1;
            end
         end
         ST_WRITE: begin
            if (amm_ready) begin
               if (beat_q == BEAT_LAST) begin
                  beat_d     = '0;
                  progress_d = progress_q + 32'd1;
                  if (burst_q == BURST_LAST) begin
                     burst_d = '0;
`ifdef DDR_INIT_VERIFY_EN
                     state_d    = ST_VERIFY;
                     progress_d = '0;
                     rd_wait_d  = 1'b0;
                     mismatch_d = 1'b0;
`else
                     state_d = ST_DONE;
                     done_d  = 1'b1;
`endif
                  end else begin
                     burst_d = burst_q + 32'd1;
                  end
               end else begin
                  beat_d = beat_q + 32'd1;
               end
            end
         end
`ifdef DDR_INIT_VERIFY_EN
         ST_VERIFY: begin
            if (!rd_wait_q) begin
               beat_d = '0;
               if (amm_ready) rd_wait_d = 1'b1;
            end else if (amm_readdatavalid) begin
               // A mismatch is remembered; the rest of the burst still drains.
               beat_bad   = mismatch_q || (amm_readdata != pat_data);
               mismatch_d = beat_bad;
               if (beat_q == BEAT_LAST) begin
                  beat_d     = '0;
                  rd_wait_d  = 1'b0;
                  progress_d = progress_q + 32'd1;
                  if (beat_bad) begin
                     state_d = ST_FAIL;
                     fail_d  = 1'b1;
                  end else if (burst_q == BURST_LAST) begin
                     state_d = ST_DONE;
                     done_d  = 1'b1;
                  end else begin
                     burst_d = burst_q + 32'd1;
                  end
               end else begin
                  beat_d = beat_q + 32'd1;
               end
            end
         end
`endif
         ST_DONE, ST_FAIL: start_go = start_cmd;
         default: state_d = ST_IDLE;
      endcase

      if (start_go) begin
         state_d    = ST_WAIT_CAL;
         timer_d    = '0;
         burst_d    = '0;
         beat_d     = '0;
         progress_d = '0;
         done_d     = 1'b0;
         fail_d     = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         timer_q    <= '0;
         burst_q    <= '0;
         beat_q     <= '0;
         progress_q <= '0;
         done_q     <= 1'b0;
         fail_q     <= 1'b0;
`ifdef DDR_INIT_VERIFY_EN
         rd_wait_q  <= 1'b0;
         mismatch_q <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         timer_q    <= timer_d;
         burst_q    <= burst_d;
         beat_q     <= beat_d;
         progress_q <= progress_d;
         done_q     <= done_d;
         fail_q     <= fail_d;
`ifdef DDR_INIT_VERIFY_EN
         rd_wait_q  <= rd_wait_d;
         mismatch_q <= mismatch_d;
`endif
      end
   end

   always_comb begin
      amm_write = (state_q == ST_WRITE);
`ifdef DDR_INIT_VERIFY_EN
      amm_read  = (state_q == ST_VERIFY) && !rd_wait_q;
`else
      amm_read  = 1'b0;
`endif
      cmd_active     = amm_write || amm_read;
      amm_addr       = cmd_active ? burst_addr : '0;
      amm_burstcount = cmd_active ? BCNT_W'(BURST_LEN) : '0;
      amm_byteenable = cmd_active ? '1 : '0;
      amm_writedata  = amm_write ? pat_data : '0;
      busy           = (state_q == ST_WAIT_CAL) || (state_q == ST_WRITE) || (state_q == ST_VERIFY);
      setup_done     = done_q;
      setup_fail     = fail_q;
      progress       = progress_q;
      dbg_state      = state_q;
   end

endmodule

// File: tb/tb_ddr_init_sequencer.sv
// Bench for ddr_init_sequencer: Avalon slave memory model, window/pattern reference
// model feeding write and status scoreboards, randomized stalls and read gaps.
module tb_ddr_init_sequencer;

   localparam int AW  = 16;
   localparam int DW  = 64;
   localparam int BL  = 4;
   localparam int BCW = 4;
   localparam int NB  = 3;
   localparam int CT  = 100;
   localparam int SBW = AW + DW;

   typedef struct packed {
      logic        done;
      logic        fail;
      logic [31:0] prog;
      logic        chk_lat;
      logic [15:0] busy_len;
   } st_exp_t;

   logic            clk = 1'b0;
   logic            rst_n = 1'b1;
   logic            cal_success = 1'b0;
   logic            cal_fail = 1'b0;
   logic            start_cmd = 1'b0;
   logic [AW-1:0]   amm_addr;
   logic [BCW-1:0]  amm_burstcount;
   logic [DW/8-1:0] amm_byteenable;
   logic            amm_write;
   logic [DW-1:0]   amm_writedata;
   logic            amm_read;
   logic [DW-1:0]   amm_readdata = '0;
   logic            amm_readdatavalid = 1'b0;
   logic            amm_ready = 1'b0;
   logic            busy;
   logic            setup_done;
   logic            setup_fail;
   logic [31:0]     progress;
   logic [2:0]      dbg_state;

   logic [SBW-1:0]  exp_q[$];
   st_exp_t         st_q[$];
   int              rd_q[$];
   logic [DW-1:0]   mem [int];

   int n_checks = 0;
   int n_fail = 0;
   int cyc = 0;
   int last_act = -100;
   int busy_cnt = 0;
   int wcount = 0;
   int run_id = 0;
   int corrupt_beat = -1;
   bit stall_en = 1'b0;

   ddr_init_sequencer #(
      .ADDR_W(AW), .DATA_W(DW), .BURST_LEN(BL), .BCNT_W(BCW), .BASE_ADDR(0),
      .NUM_BURSTS(NB), .CAL_TIMEOUT(CT), .PATTERN(1), .AUTO_START(1)
   ) dut (
      .clk(clk), .rst_n(rst_n), .cal_success(cal_success), .cal_fail(cal_fail),
      .start_cmd(start_cmd), .amm_addr(amm_addr), .amm_burstcount(amm_burstcount),
      .amm_byteenable(amm_byteenable), .amm_write(amm_write), .amm_writedata(amm_writedata),
      .amm_read(amm_read), .amm_readdata(amm_readdata), .amm_readdatavalid(amm_readdatavalid),
      .amm_ready(amm_ready), .busy(busy), .setup_done(setup_done), .setup_fail(setup_fail),
      .progress(progress), .dbg_state(dbg_state)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- checking helpers and reference model ----------------
   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [DW-1:0] exp_word(input int a);
      logic [DW-1:0] w;
      for (int l = 0; l < DW/32; l++) w[l*32 +: 32] = 32'(a);
      return w;
   endfunction

   // Whole window in order: burst b starts at b*BL, word k of it carries address b*BL+k.
   task automatic push_fill();
      for (int b = 0; b < NB; b++)
         for (int k = 0; k < BL; k++)
            exp_q.push_back({AW'(b*BL), exp_word(b*BL + k)});
   endtask

   task automatic push_status(input bit d, input bit f, input int p, input bit lat, input int bl);
      st_exp_t s;
      s.done = d; s.fail = f; s.prog = 32'(p); s.chk_lat = lat; s.busy_len = 16'(bl);
      st_q.push_back(s);
   endtask

   task automatic check_mem(input string name);
      for (int a = 0; a < NB*BL; a++) check({name, "_mem"}, mem[a], exp_word(a));
   endtask

   // ---------------- monitor / scoreboard ----------------
   int            mon_run = 0;
   int            wbeat = 0;
   bit            stalled = 1'b0;
   logic          done_prev = 1'b0;
   logic          fail_prev = 1'b0;
   logic [AW-1:0] h_addr;
   logic [DW-1:0] h_data;
   logic [BCW-1:0] h_bc;

   always @(negedge clk) begin
      logic [SBW-1:0] e;
      st_exp_t s;
      cyc++;
      if (run_id != mon_run) begin
         mon_run = run_id; busy_cnt = 0; wcount = 0;
      end
      if (!rst_n) begin
         wbeat = 0; stalled = 1'b0;
      end
      check("wr_rd_exclusive", amm_write & amm_read, 1'b0);
      if (busy) busy_cnt++;
      if (amm_write) begin
         if (stalled) begin
            check("stall_addr", amm_addr, h_addr);
            check("stall_data", amm_writedata, h_data);
            check("stall_bcount", amm_burstcount, h_bc);
         end
         if (amm_ready) begin
            if (exp_q.size() == 0) begin
               n_checks++; n_fail++;
               $display("FAIL unexpected_write: addr %0h data %0h, expected no write", amm_addr, amm_writedata);
            end else begin
               e = exp_q.pop_front();
               check("wr_addr", amm_addr, e[SBW-1:DW]);
               check("wr_data", amm_writedata, e[DW-1:0]);
               check("wr_bcount", amm_burstcount, BL);
               check("wr_byteen", amm_byteenable, {DW/8{1'b1}});
            end
            mem[int'(amm_addr) + wbeat] = amm_writedata;
            wbeat = (wbeat == BL-1) ? 0 : wbeat + 1;
            wcount++;
            last_act = cyc;
            stalled = 1'b0;
         end else begin
            stalled = 1'b1;
            h_addr = amm_addr; h_data = amm_writedata; h_bc = amm_burstcount;
         end
      end else begin
         stalled = 1'b0;
      end
      if (amm_read && amm_ready) begin
         check("rd_bcount", amm_burstcount, BL);
         rd_q.push_back(int'(amm_addr));
      end
      if (amm_readdatavalid) last_act = cyc;
      if ((setup_done && !done_prev) || (setup_fail && !fail_prev)) begin
         if (st_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL unexpected_status: done %0b fail %0b, expected no status change", setup_done, setup_fail);
         end else begin
            s = st_q.pop_front();
            check("st_done", setup_done, s.done);
            check("st_fail", setup_fail, s.fail);
            check("st_progress", progress, s.prog);
            check("st_busy_low", busy, 1'b0);
            if (s.chk_lat) check("st_latency", cyc - last_act, 1);
            if (s.busy_len != 0) check("st_busy_cycles", busy_cnt, s.busy_len);
         end
      end
      done_prev = setup_done;
      fail_prev = setup_fail;
   end

   // ---------------- Avalon slave driver ----------------
   int sl_run = 0;
   int rd_idx = 0;
   int rd_base = 0;
   int rd_k = 0;
   bit rd_active = 1'b0;

   always @(posedge clk) begin
      #1;
      if (run_id != sl_run) begin
         sl_run = run_id; rd_idx = 0;
      end
      amm_ready = stall_en ? ($urandom_range(0, 1) == 1) : 1'b1;
      amm_readdatavalid = 1'b0;
      amm_readdata = {$urandom, $urandom};
      if (!rst_n) begin
         rd_active = 1'b0;
         rd_q.delete();
      end else begin
         if (!rd_active && rd_q.size() != 0) begin
            rd_base = rd_q.pop_front(); rd_k = 0; rd_active = 1'b1;
         end
         if (rd_active && $urandom_range(0, 3) != 0) begin
            amm_readdata = mem[rd_base + rd_k];
            if (rd_idx == corrupt_beat) amm_readdata[0] = ~amm_readdata[0];
            amm_readdatavalid = 1'b1;
            rd_k++; rd_idx++;
            if (rd_k == BL) rd_active = 1'b0;
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic start_run();
      @(posedge clk); #1;
      run_id++;
      start_cmd = 1'b1;
      @(posedge clk); #1;
      start_cmd = 1'b0;
      @(negedge clk);
      check("restart_done_clr", setup_done, 1'b0);
      check("restart_fail_clr", setup_fail, 1'b0);
      check("restart_busy", busy, 1'b1);
      check("restart_progress", progress, 0);
   endtask

   task automatic wait_done(input string name);
      int n = 0;
      while (st_q.size() != 0 && n < 2000) begin
         @(posedge clk); n++;
      end
      if (st_q.size() != 0) begin
         n_checks++; n_fail++;
         $display("FAIL %s_timeout: status still pending after %0d cycles, expected done/fail", name, n);
         st_q.delete();
      end
      check({name, "_beats_left"}, exp_q.size(), 0);
      exp_q.delete();
      @(posedge clk); #1;
   endtask

   task automatic check_reset_outputs(input string name);
      check({name, "_write"}, amm_write, 1'b0);
      check({name, "_read"}, amm_read, 1'b0);
      check({name, "_addr"}, amm_addr, 0);
      check({name, "_wdata"}, amm_writedata, 0);
      check({name, "_bcount"}, amm_burstcount, 0);
      check({name, "_byteen"}, amm_byteenable, 0);
      check({name, "_busy"}, busy, 1'b0);
      check({name, "_done"}, setup_done, 1'b0);
      check({name, "_fail"}, setup_fail, 1'b0);
      check({name, "_progress"}, progress, 0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int target;
      int n;
      #2 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 check_reset_outputs("reset");

      // Auto start after reset, calibration after 10 cycles, slave always ready.
      push_fill();
      push_status(1'b1, 1'b0, NB, 1'b1, 0);
      run_id++;
      rst_n = 1'b1;
      repeat (10) @(posedge clk);
      #1 cal_success = 1'b1;
      wait_done("fill");
      check_mem("fill");

      // Restart with random backpressure.
      stall_en = 1'b1;
      mem.delete();
      push_fill();
      push_status(1'b1, 1'b0, NB, 1'b1, 0);
      start_run();
      wait_done("stall");
      check_mem("stall");
      stall_en = 1'b0;

      // Calibration never arrives: timeout after exactly CT cycles in WAIT_CAL.
      cal_success = 1'b0;
      push_status(1'b0, 1'b1, 0, 1'b0, CT);
      start_run();
      wait_done("timeout");

      // Calibration failure, then a clean restart.
      cal_fail = 1'b1;
      push_status(1'b0, 1'b1, 0, 1'b0, 1);
      start_run();
      wait_done("calfail");
      cal_fail = 1'b0;
      mem.delete();
      push_fill();
      push_status(1'b1, 1'b0, NB, 1'b1, 0);
      start_run();
      repeat ($urandom_range(2, 15)) @(posedge clk);
      #1 cal_success = 1'b1;
      wait_done("recover");

      // Reset in the middle of the second burst, then auto refill from the base.
      push_fill();
      start_run();
      target = $urandom_range(BL + 1, 2*BL - 1);
      n = 0;
      while (wcount < target && n < 500) begin
         @(posedge clk); n++;
      end
      check("midreset_reached", wcount >= target, 1'b1);
      @(posedge clk); #3;
      rst_n = 1'b0;
      #1 check_reset_outputs("midreset");
      exp_q.delete();
      repeat (2) @(posedge clk);
      mem.delete();
      push_fill();
      push_status(1'b1, 1'b0, NB, 1'b1, 0);
      run_id++;
      #3 rst_n = 1'b1;
      wait_done("refill");
      check_mem("refill");

`ifdef DDR_INIT_VERIFY_EN
      // Readback corrupts global beat 5: fail once its burst has drained.
      stall_en = 1'b1;
      corrupt_beat = 5;
      push_fill();
      push_status(1'b0, 1'b1, 5/BL + 1, 1'b1, 0);
      start_run();
      wait_done("verify_bad");
      corrupt_beat = -1;
      push_fill();
      push_status(1'b1, 1'b0, NB, 1'b1, 0);
      start_run();
      wait_done("verify_ok");
      stall_en = 1'b0;
`endif

      repeat (3) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
